// File: rtl/loadstore_unit_if.sv
// Word-wide data-memory bus between the load/store unit (master) and data memory (slave).
// req is held with stable address/data/enables until ack; read data is valid with ack.
interface loadstore_unit_if #(
   parameter int AW = 10
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_be,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_be,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/loadstore_unit.sv
// MEM-stage load/store unit: one req/ack bus access per load/store; done one cycle after ack.
// Stalls the pipeline from the request cycle through the ack cycle; misaligned accesses pulse misalign, no bus access.
module loadstore_unit #(
   parameter int AW = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [1:0]  length,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        misalign,
   loadstore_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t        state_q, state_d;
   logic          req, aligned, issue;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic [1:0]    len_q, off_q;
   logic          sign_q;
   logic [31:0]   lane, ext;

   wire unused_addr = ^addr[31:AW+2];

   assign req   = memread | memwrite;
   assign issue = (state_q == IDLE) & req & aligned;

   always_comb begin
      aligned = 1'b0;
      be_d    = 4'b1111;
      wdata_d = wdata;
      case (length)
         2'b00: begin
            aligned = 1'b1;
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
         end
         2'b01: begin
            aligned = ~addr[0];
            be_d    = 4'b0011 << addr[1:0];
            wdata_d = {2{wdata[15:0]}};
         end
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // Stall is gated by reset so an abandoned access releases the pipeline at once.
   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      done        = 1'b0;
      bus.mem_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && aligned) begin
               stall   = rst_n;
               state_d = BUS;
            end
         end
         BUS: begin
            stall       = 1'b1;
            bus.mem_req = 1'b1;
            if (bus.mem_ack) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lane = bus.mem_rdata >> {off_q, 3'b000};
      ext  = lane;
      case (len_q)
         2'b00:   ext = {{24{sign_q & lane[7]}}, lane[7:0]};
         2'b01:   ext = {{16{sign_q & lane[15]}}, lane[15:0]};
         default: ext = lane;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         misalign <= 1'b0;
         rdata    <= 32'h0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         be_q     <= 4'h0;
         wdata_q  <= 32'h0;
         len_q    <= 2'b00;
         off_q    <= 2'b00;
         sign_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         misalign <= (state_q == IDLE) & req & ~aligned;
         if (issue) begin
            we_q    <= memwrite;
            addr_q  <= addr[AW+1:2];
            be_q    <= be_d;
            wdata_q <= wdata_d;
            len_q   <= length;
            off_q   <= addr[1:0];
            sign_q  <= sign;
         end
         if ((state_q == BUS) && bus.mem_ack && !we_q) rdata <= ext;
      end
   end

   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_wdata = wdata_q;

endmodule
